// File: rtl/tt_mux_pkg.sv
// Shared types and bus field positions for the project mux controller.
package tt_mux_pkg;

  localparam int unsigned IW_W   = 18;
  localparam int unsigned OW_W   = 24;
  localparam int unsigned PAD_W  = 8;
  localparam int unsigned CNT_W  = 8;

  // Bit positions inside the broadcast iw bus
  localparam int unsigned IW_CLK = 0;
  localparam int unsigned IW_RST = 1;
  localparam int unsigned IW_UI  = 2;
  localparam int unsigned IW_UIO = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    SWITCH = 3'd2,
    RESET  = 3'd3,
    ACTIVE = 3'd4
  } state_e;

endpackage

// File: rtl/tt_ow_mux.sv
// Registered N_PROJ:1 selector of the project output words; zero when disabled.
module tt_ow_mux
  import tt_mux_pkg::*;
#(
  parameter int unsigned N_PROJ = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic [ADDR_W-1:0]        sel_i,
  input  logic [OW_W*N_PROJ-1:0]   ow_all_i,
  output logic [OW_W-1:0]          ow_o
);

  logic [OW_W-1:0] ow_d;
  logic [OW_W-1:0] ow_q;

  // Pick the addressed slot; a disabled or out-of-range select yields zero (pads become inputs)
  always_comb begin
    ow_d = '0;
    if (en_i) begin
      for (int k = 0; k < int'(N_PROJ); k++) begin
        if (sel_i == ADDR_W'(k)) begin
          ow_d = ow_all_i[k*OW_W +: OW_W];
        end
      end
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ow_q <= '0;
    end else begin
      ow_q <= ow_d;
    end
  end

  assign ow_o = ow_q;

endmodule

// File: rtl/tt_proj_mux_ctrl.sv
// Project select controller: sequences drain -> switch -> forced reset -> active.
module tt_proj_mux_ctrl
  import tt_mux_pkg::*;
#(
  parameter int unsigned N_PROJ    = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned RST_CYC   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sel_valid,
  input  logic [ADDR_W-1:0]        sel_addr,
  input  logic                     sel_none,
  output logic                     sel_ready,
  output logic                     sel_err,
  output logic                     busy,
  output logic [ADDR_W-1:0]        cur_addr,
  input  logic                     pad_clk,
  input  logic                     pad_rst_n,
  input  logic [PAD_W-1:0]         pad_ui,
  input  logic [PAD_W-1:0]         pad_uio,
  output logic [IW_W-1:0]          iw,
  output logic [N_PROJ-1:0]        ena_o,
  input  logic [OW_W*N_PROJ-1:0]   ow_all,
  output logic [OW_W-1:0]          ow_sel
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                none_q, none_d;
  logic                sel_err_q, err_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                force_q, force_d;
  logic                ena_on_d;
  logic [N_PROJ-1:0]   ena_q, ena_d;
  logic                accept;
  logic                addr_ok;

  // Next state, counter, latched request and next output values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_addr_d = cur_addr_q;
    addr_d     = addr_q;
    none_d     = none_q;
    err_d      = 1'b0;
    accept     = sel_valid & ready_q;
    addr_ok    = 32'(sel_addr) < N_PROJ;

    unique case (state_q)
      IDLE: begin
        // Nothing is enabled, so a valid select skips the drain
        if (accept && !sel_none) begin
          if (addr_ok) begin
            addr_d  = sel_addr;
            none_d  = 1'b0;
            state_d = SWITCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (accept) begin
          if (sel_none) begin
            none_d  = 1'b1;
            cnt_d   = CNT_W'(DRAIN_CYC - 1);
            state_d = DRAIN;
          end else if (addr_ok) begin
            addr_d  = sel_addr;
            none_d  = 1'b0;
            cnt_d   = CNT_W'(DRAIN_CYC - 1);
            state_d = DRAIN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = none_q ? IDLE : SWITCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SWITCH: begin
        cur_addr_d = addr_q;
        cnt_d      = CNT_W'(RST_CYC - 1);
        state_d    = RESET;
      end
      RESET: begin
        if (cnt_q == '0) begin
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d  = (state_d == IDLE) || (state_d == ACTIVE);
    busy_d   = (state_d == DRAIN) || (state_d == SWITCH) || (state_d == RESET);
    ena_on_d = (state_d == RESET) || (state_d == ACTIVE);
    force_d  = (state_d != ACTIVE);
  end

  // One-hot enable decode of the next selected slot
  always_comb begin
    ena_d = '0;
    for (int k = 0; k < int'(N_PROJ); k++) begin
      ena_d[k] = ena_on_d && (cur_addr_d == ADDR_W'(k));
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_addr_q <= '0;
      addr_q     <= '0;
      none_q     <= 1'b0;
      sel_err_q  <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      force_q    <= 1'b1;
      ena_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_addr_q <= cur_addr_d;
      addr_q     <= addr_d;
      none_q     <= none_d;
      sel_err_q  <= err_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      force_q    <= force_d;
      ena_q      <= ena_d;
    end
  end

  tt_ow_mux #(
    .N_PROJ (N_PROJ),
    .ADDR_W (ADDR_W)
  ) u_ow_mux (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (ena_on_d),
    .sel_i    (cur_addr_d),
    .ow_all_i (ow_all),
    .ow_o     (ow_sel)
  );

  // Broadcast bus: pad signals pass straight through, project reset gated by the sequencer
  assign iw[IW_CLK]           = pad_clk;
  assign iw[IW_RST]           = pad_rst_n & ~force_q;
  assign iw[IW_UI +: PAD_W]   = pad_ui;
  assign iw[IW_UIO +: PAD_W]  = pad_uio;

  assign sel_ready = ready_q;
  assign sel_err   = sel_err_q;
  assign busy      = busy_q;
  assign cur_addr  = cur_addr_q;
  assign ena_o     = ena_q;

endmodule

// File: tb/tb_tt_proj_mux_ctrl.sv
// Bench for tt_proj_mux_ctrl: timeline model plus directed literal checks.
module tb_tt_proj_mux_ctrl;

  localparam int N  = 16;
  localparam int AW = 5;
  localparam int D  = 4;
  localparam int R  = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sel_valid = 1'b0;
  logic [AW-1:0]   sel_addr = '0;
  logic            sel_none = 1'b0;
  logic            sel_ready, sel_err, busy;
  logic [AW-1:0]   cur_addr;
  logic            pad_clk = 1'b0;
  logic            pad_rst_n = 1'b1;
  logic [7:0]      pad_ui = 8'h00;
  logic [7:0]      pad_uio = 8'h00;
  logic [17:0]     iw;
  logic [N-1:0]    ena_o;
  logic [24*N-1:0] ow_all = '0;
  logic [23:0]     ow_sel;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: target project (-1 = none), edges remaining until settled, current slot
  int          m_proj = -1;
  int          m_r    = 0;
  int          m_cur  = 0;
  bit          m_err  = 1'b0;
  logic [23:0] m_ow   = '0;

  tt_proj_mux_ctrl #(
    .N_PROJ    (N),
    .ADDR_W    (AW),
    .DRAIN_CYC (D),
    .RST_CYC   (R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel_valid (sel_valid),
    .sel_addr  (sel_addr),
    .sel_none  (sel_none),
    .sel_ready (sel_ready),
    .sel_err   (sel_err),
    .busy      (busy),
    .cur_addr  (cur_addr),
    .pad_clk   (pad_clk),
    .pad_rst_n (pad_rst_n),
    .pad_ui    (pad_ui),
    .pad_uio   (pad_uio),
    .iw        (iw),
    .ena_o     (ena_o),
    .ow_all    (ow_all),
    .ow_sel    (ow_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ena_on();
    return (m_proj >= 0) && (m_r <= R);
  endfunction

  // Timeline model: a switch from a live project costs D+1+R edges, from idle R+1, a deselect D
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_proj = -1;
      m_r    = 0;
      m_cur  = 0;
      m_err  = 1'b0;
      m_ow   = '0;
    end else begin
      m_err = 1'b0;
      if (m_r > 0) begin
        m_r--;
        if (m_r == R && m_proj >= 0) m_cur = m_proj;
      end else if (sel_valid) begin
        if (sel_none) begin
          if (m_proj >= 0) begin
            m_proj = -1;
            m_r    = D;
          end
        end else if (int'(sel_addr) < N) begin
          m_r    = (m_proj >= 0) ? (D + 1 + R) : (R + 1);
          m_proj = int'(sel_addr);
        end else begin
          m_err = 1'b1;
        end
      end
      m_ow = m_ena_on() ? ow_all[m_cur*24 +: 24] : 24'h0;
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [N-1:0] e_ena;
      logic [17:0]  e_iw;
      e_ena = m_ena_on() ? (N'(1) << m_proj) : '0;
      e_iw  = {pad_uio, pad_ui, pad_rst_n & ((m_proj >= 0) && (m_r == 0)), pad_clk};
      check("m_ena",   64'(ena_o),     64'(e_ena));
      check("m_cur",   64'(cur_addr),  64'(m_cur));
      check("m_ready", 64'(sel_ready), 64'(m_r == 0));
      check("m_busy",  64'(busy),      64'(m_r > 0));
      check("m_err",   64'(sel_err),   64'(m_err));
      check("m_iw",    64'(iw),        64'(e_iw));
      check("m_ow",    64'(ow_sel),    64'(m_ow));
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Present one request for exactly one sampling edge; returns 2 time units after that edge
  task automatic req(input int addr, input bit none);
    @(posedge clk);
    #2;
    sel_valid = 1'b1;
    sel_addr  = AW'(addr);
    sel_none  = none;
    @(posedge clk);
    #2;
    sel_valid = 1'b0;
    sel_none  = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      ow_all[k*24 +: 24] = {8'(k), 8'(k * 16), 8'hF0 ^ 8'(k)};
    end
    pad_ui  = 8'h3C;
    pad_uio = 8'hC3;
    pad_clk = 1'b1;

    // Reset values
    #12;
    check("rst_ena",   64'(ena_o),     64'h0);
    check("rst_ready", 64'(sel_ready), 64'h1);
    check("rst_busy",  64'(busy),      64'h0);
    check("rst_iw1",   64'(iw[1]),     64'h0);
    check("rst_ow",    64'(ow_sel),    64'h0);
    cmp_en = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_cycles(2);

    // Select 3 from idle: switch, 8 reset cycles with ena, then active
    req(3, 1'b0);
    check("sw_ena0", 64'(ena_o), 64'h0);
    wait_cycles(1);
    check("rst3_ena", 64'(ena_o), 64'h0008);
    check("rst3_iw1", 64'(iw[1]), 64'h0);
    wait_cycles(7);
    check("rst3_busy", 64'(busy), 64'h1);
    wait_cycles(1);
    check("act3_ready", 64'(sel_ready), 64'h1);
    check("act3_iw", 64'(iw), 64'h30CF3);

    // Output return path, one cycle of latency; other slots ignored
    ow_all[3*24 +: 24] = 24'hA55AC3;
    wait_cycles(1);
    check("ow3", 64'(ow_sel), 64'hA55AC3);
    ow_all[5*24 +: 24] = 24'h123456;
    pad_clk = 1'b0;
    pad_rst_n = 1'b0;
    wait_cycles(1);
    check("ow3_hold", 64'(ow_sel), 64'hA55AC3);
    check("padrst_iw1", 64'(iw[1]), 64'h0);
    pad_rst_n = 1'b1;
    pad_ui = 8'h81;

    // Switch 3 -> 7 from active
    req(7, 1'b0);
    check("drain_ena", 64'(ena_o), 64'h0);
    check("drain_cur", 64'(cur_addr), 64'd3);
    check("drain_ow", 64'(ow_sel), 64'h0);
    wait_cycles(4);
    check("switch_ena", 64'(ena_o), 64'h0);
    wait_cycles(1);
    check("rst7_ena", 64'(ena_o), 64'h0080);
    check("rst7_cur", 64'(cur_addr), 64'd7);
    wait_cycles(7);
    check("rst7_busy", 64'(busy), 64'h1);
    wait_cycles(1);
    check("act7_busy", 64'(busy), 64'h0);
    check("act7_iw1", 64'(iw[1]), 64'h1);

    // Out-of-range address: error pulse, nothing else moves
    req(20, 1'b0);
    check("err_pulse", 64'(sel_err), 64'h1);
    check("err_ena", 64'(ena_o), 64'h0080);
    check("err_cur", 64'(cur_addr), 64'd7);
    wait_cycles(1);
    check("err_clear", 64'(sel_err), 64'h0);

    // Request while in forced reset is dropped
    req(2, 1'b0);
    wait_cycles(6);
    check("rst2_ready", 64'(sel_ready), 64'h0);
    req(9, 1'b0);
    wait_cycles(10);
    check("ign_cur", 64'(cur_addr), 64'd2);
    check("ign_ena", 64'(ena_o), 64'h0004);

    // Deselect everything: drain then idle
    req(11, 1'b1);
    check("none_ena", 64'(ena_o), 64'h0);
    wait_cycles(3);
    check("none_busy", 64'(busy), 64'h1);
    wait_cycles(1);
    check("idle_ready", 64'(sel_ready), 64'h1);
    check("idle_busy", 64'(busy), 64'h0);
    check("idle_ow", 64'(ow_sel), 64'h0);
    check("idle_iw1", 64'(iw[1]), 64'h0);

    // Deselect and bad address while idle
    req(0, 1'b1);
    wait_cycles(1);
    check("idle_none_busy", 64'(busy), 64'h0);
    req(31, 1'b0);
    check("idle_err", 64'(sel_err), 64'h1);

    // Async reset in the middle of a drain
    req(5, 1'b0);
    wait_cycles(10);
    check("act5_ena", 64'(ena_o), 64'h0020);
    req(1, 1'b0);
    wait_cycles(2);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_ena",   64'(ena_o),     64'h0);
    check("arst_ow",    64'(ow_sel),    64'h0);
    check("arst_ready", 64'(sel_ready), 64'h1);
    check("arst_busy",  64'(busy),      64'h0);
    check("arst_cur",   64'(cur_addr),  64'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Recovery after reset
    req(14, 1'b0);
    wait_cycles(9);
    check("act14_ena", 64'(ena_o), 64'h4000);
    check("act14_cur", 64'(cur_addr), 64'd14);
    wait_cycles(2);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
